// File: rtl/step_phase_gen.sv
// Stepper-motor phase generator: accepts move commands, walks a 3-bit index through an 8-entry coil table.
// Latency: coil valid the cycle after accept, step k lands STEP_PERIOD*k cycles later, done pulses with the last step.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped. Macro STEP_HALF_STEP_EN adds cmd_half.
module step_phase_gen #(
    parameter int unsigned STEP_PERIOD = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_steps,
`ifdef STEP_HALF_STEP_EN
    input  logic        cmd_half,
`endif
    input  logic        abort,
    output logic [3:0]  coil,
    output logic        step_tick,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [19:0] TIMER_LAST = 20'(STEP_PERIOD - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] timer_q, timer_d;
    logic [15:0] remaining_q, remaining_d;
    logic        dir_q, dir_d;
    logic        coil_en_q, coil_en_d;
    logic        tick_q, tick_d;
    logic        half_q, half_d;
    logic [2:0]  step_inc;
    logic        accept;
    logic        step_evt;

    function automatic logic [3:0] phase_of(input logic [2:0] i);
        case (i)
            3'd0:    phase_of = 4'b1000;
            3'd1:    phase_of = 4'b1100;
            3'd2:    phase_of = 4'b0100;
            3'd3:    phase_of = 4'b0110;
            3'd4:    phase_of = 4'b0010;
            3'd5:    phase_of = 4'b0011;
            3'd6:    phase_of = 4'b0001;
            default: phase_of = 4'b1001;
        endcase
    endfunction

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign step_tick = tick_q;
    // Coils stay de-energised after reset until the first real move; afterwards the last pattern holds torque.
    assign coil      = coil_en_q ? phase_of(idx_q) : 4'b0000;

    assign accept   = cmd_valid && (state_q == S_IDLE);
    assign step_evt = (state_q == S_RUN) && (timer_q == TIMER_LAST);

    // Next-state logic: command capture, dwell timer, index stepping and termination.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        coil_en_d   = coil_en_q;
        tick_d      = 1'b0;
        half_d      = half_q;
        step_inc    = half_q ? 3'd1 : 3'd2;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d = cmd_dir;
`ifdef STEP_HALF_STEP_EN
                    half_d = cmd_half;
`else
                    half_d = 1'b0;
`endif
                    if (cmd_steps != 16'd0) begin
                        state_d     = S_RUN;
                        remaining_d = cmd_steps;
                        timer_d     = 20'd0;
                        coil_en_d   = 1'b1;
                        // Full-step mode parks on an odd (two-coil) entry for maximum torque.
                        idx_d       = half_d ? idx_q : (idx_q | 3'd1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (step_evt) begin
                    timer_d     = 20'd0;
                    idx_d       = dir_q ? (idx_q + step_inc) : (idx_q - step_inc);
                    remaining_d = remaining_q - 16'd1;
                    tick_d      = 1'b1;
                    if (remaining_q == 16'd1) begin
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = timer_q + 20'd1;
                end
                // A step landing on the abort edge still executes; done pulses once either way.
                if (abort) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd1;
            timer_q     <= 20'd0;
            remaining_q <= 16'd0;
            dir_q       <= 1'b0;
            coil_en_q   <= 1'b0;
            tick_q      <= 1'b0;
            half_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            coil_en_q   <= coil_en_d;
            tick_q      <= tick_d;
            half_q      <= half_d;
        end
    end

endmodule

// File: tb/tb_step_phase_gen.sv
// Directed bench for step_phase_gen with STEP_PERIOD=4.
// Expected per-cycle outputs are queued when a command is issued and popped each cycle.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_step_phase_gen;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic        abort;
    logic [3:0]  coil;
    logic        step_tick;
    logic        busy;
    logic        done;
`ifdef STEP_HALF_STEP_EN
    logic        cmd_half;
`endif

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    step_phase_gen #(.STEP_PERIOD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
`ifdef STEP_HALF_STEP_EN
        .cmd_half  (cmd_half),
`endif
        .abort     (abort),
        .coil      (coil),
        .step_tick (step_tick),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue n identical cycles of expected {coil, tick, done, busy, ready}; ready is the inverse of busy.
    task automatic push_exp(input int n, input logic [3:0] c, input logic t, input logic d,
                            input logic b, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.v   = {c, t, d, b, ~b};
            sb.push_back(e);
        end
    endtask

    task automatic check_now();
        exp_t       e;
        logic [7:0] obs;
        obs = {coil, step_tick, done, busy, cmd_ready};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow observed=%b expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s observed coil/tick/done/busy/rdy=%b expected=%b", e.tag, obs, e.v);
            end
        end
    endtask

    // Offer a command in cycle T, then check ncyc cycles; abort is high during cycle abort_at only.
    task automatic run_cmd(input logic dir, input logic [15:0] steps, input int ncyc,
                           input int abort_at, input int valid_cycles);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            check_now();
            if (c >= valid_cycles) cmd_valid = 1'b0;
            abort = (c == abort_at);
        end
        abort = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1, 4'b0000, 0, 0, 0, "post_reset");
        #1 check_now();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dir     = 1'b0;
        cmd_steps   = 16'd0;
        abort       = 1'b0;
`ifdef STEP_HALF_STEP_EN
        cmd_half    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_exp(1, 4'b0000, 0, 0, 0, "reset_state");
        @(negedge clk);
        check_now();

        // Forward 3 full steps from idx 1.
        push_exp(4, 4'b1100, 0, 0, 1, "fwd3_hold1");
        push_exp(1, 4'b0110, 1, 0, 1, "fwd3_step1");
        push_exp(3, 4'b0110, 0, 0, 1, "fwd3_hold2");
        push_exp(1, 4'b0011, 1, 0, 1, "fwd3_step2");
        push_exp(3, 4'b0011, 0, 0, 1, "fwd3_hold3");
        push_exp(1, 4'b1001, 1, 1, 1, "fwd3_last");
        push_exp(1, 4'b1001, 0, 0, 0, "fwd3_idle");
        run_cmd(1'b1, 16'd3, 14, 0, 1);

        // Reverse 2 from idx 1, wrapping below zero.
        do_reset();
        push_exp(4, 4'b1100, 0, 0, 1, "rev2_hold1");
        push_exp(1, 4'b1001, 1, 0, 1, "rev2_step1");
        push_exp(3, 4'b1001, 0, 0, 1, "rev2_hold2");
        push_exp(1, 4'b0011, 1, 1, 1, "rev2_last");
        push_exp(1, 4'b0011, 0, 0, 0, "rev2_idle");
        run_cmd(1'b0, 16'd2, 10, 0, 1);

        // Next command resumes from idx 5.
        push_exp(4, 4'b0011, 0, 0, 1, "resume_hold");
        push_exp(1, 4'b1001, 1, 1, 1, "resume_last");
        push_exp(1, 4'b1001, 0, 0, 0, "resume_idle");
        run_cmd(1'b1, 16'd1, 6, 0, 1);

        // Zero-step command: one DONE cycle, coil untouched.
        push_exp(1, 4'b1001, 0, 1, 1, "zero_done");
        push_exp(2, 4'b1001, 0, 0, 0, "zero_idle");
        run_cmd(1'b1, 16'd0, 3, 0, 1);

        // cmd_valid held through the whole move must not queue a second command.
        push_exp(4, 4'b1001, 0, 0, 1, "held_hold");
        push_exp(1, 4'b1100, 1, 1, 1, "held_last");
        push_exp(1, 4'b1100, 0, 0, 0, "held_idle");
        run_cmd(1'b1, 16'd1, 6, 0, 5);

        // Abort while idle has no effect.
        @(negedge clk);
        abort = 1'b1;
        push_exp(2, 4'b1100, 0, 0, 0, "abort_idle");
        repeat (2) begin
            @(negedge clk);
            check_now();
        end
        abort = 1'b0;

        // Abort mid-move after one step.
        do_reset();
        push_exp(4, 4'b1100, 0, 0, 1, "abort_hold");
        push_exp(1, 4'b0110, 1, 0, 1, "abort_step1");
        push_exp(1, 4'b0110, 0, 0, 1, "abort_t6");
        push_exp(1, 4'b0110, 0, 1, 1, "abort_done");
        push_exp(1, 4'b0110, 0, 0, 0, "abort_ready");
        run_cmd(1'b1, 16'd10, 8, 6, 1);

        // Abort on the edge of the terminal step: step executes, single done.
        push_exp(4, 4'b0110, 0, 0, 1, "abort_term_hold");
        push_exp(1, 4'b0011, 1, 1, 1, "abort_term_last");
        push_exp(1, 4'b0011, 0, 0, 0, "abort_term_idle");
        run_cmd(1'b1, 16'd1, 6, 4, 1);

        // Reset mid-move: coil drops immediately, no done afterwards.
        push_exp(4, 4'b0011, 0, 0, 1, "rstmid_hold");
        push_exp(1, 4'b1001, 1, 0, 1, "rstmid_step1");
        push_exp(1, 4'b1001, 0, 0, 1, "rstmid_t6");
        run_cmd(1'b1, 16'd5, 6, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        push_exp(1, 4'b0000, 0, 0, 0, "rstmid_async");
        #1 check_now();
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(3, 4'b0000, 0, 0, 0, "rstmid_no_done");
        repeat (3) begin
            @(negedge clk);
            check_now();
        end

`ifdef STEP_HALF_STEP_EN
        // Half-step forward 2 from idx 1.
        cmd_half = 1'b1;
        push_exp(4, 4'b1100, 0, 0, 1, "half_hold1");
        push_exp(1, 4'b0100, 1, 0, 1, "half_step1");
        push_exp(3, 4'b0100, 0, 0, 1, "half_hold2");
        push_exp(1, 4'b0110, 1, 1, 1, "half_last");
        push_exp(1, 4'b0110, 0, 0, 0, "half_idle");
        run_cmd(1'b1, 16'd2, 10, 0, 1);
        cmd_half = 1'b0;
`endif

        vectors++;
        assert (sb.size() === 0) else begin
            miscompares++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
